// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter:
// RUDataWrSrc encoding and the load-return queue entry.
package wb_pkg;

   localparam logic [1:0] WB_ALURES    = 2'b00;
   localparam logic [1:0] WB_DATARD    = 2'b01;
   localparam logic [1:0] WB_PC_OFFSET = 2'b10;

   localparam int RD_W   = 5;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // Only ALU result and PC+offset may be requested by the core.
   function automatic logic src_legal(input logic [1:0] src);
      return (src == WB_ALURES) || (src == WB_PC_OFFSET);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-return FIFO. Extra pointer bit separates full from empty; every
// slot's rd plus an occupancy mask is exported for the WAW compare.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  wb_entry_t                  din,
   output wb_entry_t                  head,
   output logic                       full,
   output logic                       empty,
   output logic [DEPTH-1:0]           entry_valid,
   output logic [DEPTH-1:0][RD_W-1:0] entry_rd
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   wb_entry_t      mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [AW:0]    count;
   logic [AW-1:0]  offs;
   logic           do_push;
   logic           do_pop;

   assign count = wr_ptr - rd_ptr;
   assign empty = (count == '0);
   assign full  = (count == DEPTH_CNT);
   assign head  = mem[rd_ptr[AW-1:0]];

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   always_comb begin
      offs        = '0;
      entry_valid = '0;
      entry_rd    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs           = AW'(i) - rd_ptr[AW-1:0];
         entry_valid[i] = ({1'b0, offs} < count);
         entry_rd[i]    = mem[i].rd;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: core writeback vs. queued load returns,
// with an age limit on the FIFO head and WAW stalls for the core.
module rf_wb_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_valid,
   input  logic [4:0]  core_rd,
   input  logic [1:0]  core_src,
   input  logic [31:0] core_alu,
   input  logic [31:0] core_pc_off,
   output logic        core_stall,
   input  logic        ld_valid,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_data,
   output logic [1:0]  wb_sel,
   output logic        err_illegal
);

   localparam int AGE_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

   wb_entry_t                  fifo_din;
   wb_entry_t                  head;
   logic                       full;
   logic                       empty;
   logic [DEPTH-1:0]           entry_valid;
   logic [DEPTH-1:0][RD_W-1:0] entry_rd;
   logic                       ld_push;

   logic [AGE_W-1:0] age;
   logic             core_legal;
   logic             waw;
   logic             core_ok;
   logic             load_grant;
   logic             core_grant;

   assign fifo_din = '{rd: ld_rd, data: ld_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (ld_push),
      .pop         (load_grant),
      .din         (fifo_din),
      .head        (head),
      .full        (full),
      .empty       (empty),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   always_comb begin
      waw = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (entry_rd[i] == core_rd)) waw = 1'b1;
      end
      waw = waw & (core_rd != '0);
   end

   // Arbitration looks only at the registered head, never at an incoming return.
   assign core_legal = src_legal(core_src);
   assign core_ok    = core_valid & core_legal & ~waw;
   assign load_grant = ~empty & (~core_ok | full | (age == AGE_MAX));
   assign core_grant = core_ok & ~load_grant;
   assign core_stall = core_valid & core_legal & ~core_grant;

   // Writes to x0 carry no information, so they are accepted and dropped here.
   assign ld_ready = ~full | load_grant;
   assign ld_push  = ld_valid & ld_ready & (ld_rd != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         age <= '0;
      end else if (empty || load_grant) begin
         age <= '0;
      end else if (core_grant && (age != AGE_MAX)) begin
         age <= age + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we   <= 1'b0;
         rf_rd   <= '0;
         rf_data <= '0;
         wb_sel  <= WB_ALURES;
      end else begin
         rf_we <= 1'b0;
         if (load_grant) begin
            rf_we   <= (head.rd != '0);
            rf_rd   <= head.rd;
            rf_data <= head.data;
            wb_sel  <= WB_DATARD;
         end else if (core_grant) begin
            rf_we   <= (core_rd != '0);
            rf_rd   <= core_rd;
            rf_data <= (core_src == WB_PC_OFFSET) ? core_pc_off : core_alu;
            wb_sel  <= core_src;
         end
      end
   end

   // An illegal request is consumed silently apart from this sticky flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_illegal <= 1'b0;
      end else if (core_valid && !core_legal) begin
         err_illegal <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: per-cycle stimulus rows with the
// expected grant, a load-queue model and a write scoreboard.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_valid = 1'b0;
   logic [4:0]  core_rd = '0;
   logic [1:0]  core_src = '0;
   logic [31:0] core_alu = '0;
   logic [31:0] core_pc_off = '0;
   logic        core_stall;
   logic        ld_valid = 1'b0;
   logic [4:0]  ld_rd = '0;
   logic [31:0] ld_data = '0;
   logic        ld_ready;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   logic [1:0]  wb_sel;
   logic        err_illegal;

   int total = 0;
   int bad   = 0;

   logic [38:0] sb [$];   // expected writes {rd, data, sel}
   logic [36:0] ldq [$];  // model of queued loads {rd, data}

   localparam int G_NONE = 0, G_CORE = 1, G_LOAD = 2;

   rf_wb_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .core_valid  (core_valid),
      .core_rd     (core_rd),
      .core_src    (core_src),
      .core_alu    (core_alu),
      .core_pc_off (core_pc_off),
      .core_stall  (core_stall),
      .ld_valid    (ld_valid),
      .ld_rd       (ld_rd),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .rf_we       (rf_we),
      .rf_rd       (rf_rd),
      .rf_data     (rf_data),
      .wb_sel      (wb_sel),
      .err_illegal (err_illegal)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle of stimulus; g names who the arbiter must grant this cycle.
   task automatic drive(input logic cv, input logic [4:0] crd, input logic [1:0] csrc,
                        input logic [31:0] cval, input logic lv, input logic [4:0] lrd,
                        input logic [31:0] ldat, input logic xs, input logic xr, input int g);
      logic [36:0] e;
      core_valid  = cv;
      core_rd     = crd;
      core_src    = csrc;
      core_alu    = (csrc == 2'b10) ? ~cval : cval;
      core_pc_off = (csrc == 2'b10) ? cval : ~cval;
      ld_valid    = lv;
      ld_rd       = lrd;
      ld_data     = ldat;
      #1;
      check_eq("core_stall", core_stall, xs);
      check_eq("ld_ready", ld_ready, xr);
      if (g == G_LOAD) begin
         if (ldq.size() == 0) begin
            check_eq("model_ldq_nonempty", 0, 1);
         end else begin
            e = ldq.pop_front();
            sb.push_back({e, 2'b01});
         end
      end else if (g == G_CORE && crd != 0) begin
         sb.push_back({crd, cval, csrc});
      end
      if (lv && xr && lrd != 0) ldq.push_back({lrd, ldat});
      step();
   endtask

   task automatic idle(input int g);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, g);
   endtask

   always @(negedge clk) begin
      if (!rst && rf_we) begin
         if (sb.size() == 0) check_eq("unexpected_write", {rf_rd, rf_data, wb_sel}, 0);
         else check_eq("write", {rf_rd, rf_data, wb_sel}, sb.pop_front());
      end
   end

   initial begin
      #12;
      check_eq("rst_rf_we", rf_we, 0);
      check_eq("rst_rf_rd", rf_rd, 0);
      check_eq("rst_rf_data", rf_data, 0);
      check_eq("rst_wb_sel", wb_sel, 0);
      check_eq("rst_err", err_illegal, 0);
      check_eq("rst_ld_ready", ld_ready, 1);
      step();
      rst = 1'b0;
      step();

      // jal wins over a queued load, then the load drains
      drive(0, 0, 0, 0, 1, 7, 32'hDEAD, 0, 1, G_NONE);
      drive(1, 1, 2'b10, 32'h104, 0, 0, 0, 0, 1, G_CORE);
      check_eq("jal_sel", wb_sel, 2'b10);
      check_eq("jal_data", rf_data, 32'h104);
      idle(G_LOAD);
      check_eq("ld_sel", wb_sel, 2'b01);
      check_eq("ld_rd", rf_rd, 7);
      check_eq("ld_data", rf_data, 32'hDEAD);
      idle(G_NONE);

      // age limit: core wins three times, then the load is forced
      drive(1, 2, 0, 32'h101, 1, 12, 32'hC0, 0, 1, G_CORE);
      drive(1, 2, 0, 32'h102, 0, 0, 0, 0, 1, G_CORE);
      drive(1, 2, 0, 32'h103, 0, 0, 0, 0, 1, G_CORE);
      drive(1, 2, 0, 32'h104, 0, 0, 0, 0, 1, G_CORE);
      drive(1, 2, 0, 32'h105, 0, 0, 0, 1, 1, G_LOAD);
      check_eq("age_ld_rd", rf_rd, 12);
      drive(1, 2, 0, 32'h105, 0, 0, 0, 0, 1, G_CORE);
      idle(G_NONE);

      // fill to full while the core streams; push during full-cycle pop
      drive(1, 3, 0, 32'h201, 1, 20, 32'h2000, 0, 1, G_CORE);
      drive(1, 3, 0, 32'h202, 1, 21, 32'h2100, 0, 1, G_CORE);
      drive(1, 3, 0, 32'h203, 1, 22, 32'h2200, 0, 1, G_CORE);
      drive(1, 3, 0, 32'h204, 1, 23, 32'h2300, 0, 1, G_CORE);
      drive(1, 3, 0, 32'h205, 1, 24, 32'h2400, 1, 1, G_LOAD);
      drive(1, 3, 0, 32'h205, 0, 0, 0, 1, 1, G_LOAD);
      idle(G_LOAD);
      idle(G_LOAD);
      idle(G_LOAD);
      idle(G_NONE);
      check_eq("fill_model_empty", ldq.size(), 0);

      // WAW against a non-head entry, then against the head
      drive(1, 4, 0, 32'h401, 1, 5, 32'h500, 0, 1, G_CORE);
      drive(1, 4, 0, 32'h402, 1, 9, 32'h900, 0, 1, G_CORE);
      drive(1, 9, 0, 32'h909, 0, 0, 0, 1, 1, G_LOAD);
      drive(1, 9, 0, 32'h909, 0, 0, 0, 1, 1, G_LOAD);
      check_eq("waw_ld_rd", rf_rd, 9);
      drive(1, 9, 0, 32'h909, 0, 0, 0, 0, 1, G_CORE);
      check_eq("waw_core_data", rf_data, 32'h909);
      idle(G_NONE);

      // rd = 0 requests and illegal core_src
      drive(1, 0, 0, 32'h55, 0, 0, 0, 0, 1, G_CORE);
      check_eq("rd0_core_we", rf_we, 0);
      drive(0, 0, 0, 0, 1, 0, 32'h66, 0, 1, G_NONE);
      check_eq("rd0_ld_we", rf_we, 0);
      idle(G_NONE);
      check_eq("rd0_ld_dropped", rf_we, 0);
      drive(1, 6, 2'b01, 32'h66, 0, 0, 0, 0, 1, G_NONE);
      check_eq("illegal_we", rf_we, 0);
      check_eq("illegal_err", err_illegal, 1);
      drive(1, 6, 2'b11, 32'h67, 0, 0, 0, 0, 1, G_NONE);
      drive(1, 8, 0, 32'h88, 0, 0, 0, 0, 1, G_CORE);
      check_eq("err_sticky", err_illegal, 1);
      idle(G_NONE);

      // reset mid-traffic with three loads queued
      drive(1, 0, 2'b10, 32'h77, 1, 3, 32'h300, 0, 1, G_CORE);
      drive(1, 0, 2'b10, 32'h77, 1, 4, 32'h400, 0, 1, G_CORE);
      drive(1, 0, 2'b10, 32'h77, 1, 5, 32'h500, 0, 1, G_CORE);
      check_eq("pre_rst_data", rf_data, 32'h77);
      core_valid = 0;
      ld_valid   = 0;
      rst        = 1'b1;
      ldq.delete();
      #1;
      check_eq("mid_rst_we", rf_we, 0);
      check_eq("mid_rst_rd", rf_rd, 0);
      check_eq("mid_rst_data", rf_data, 0);
      check_eq("mid_rst_sel", wb_sel, 0);
      check_eq("mid_rst_err", err_illegal, 0);
      check_eq("mid_rst_ready", ld_ready, 1);
      step();
      rst = 1'b0;
      idle(G_NONE);
      idle(G_NONE);
      idle(G_NONE);
      drive(1, 5, 0, 32'h11, 0, 0, 0, 0, 1, G_CORE);
      check_eq("post_rst_we", rf_we, 1);
      check_eq("post_rst_rd", rf_rd, 5);
      check_eq("post_rst_data", rf_data, 32'h11);
      idle(G_NONE);
      idle(G_NONE);

      check_eq("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
